// File: rtl/rv32_pkg.sv
// Shared RV32I fetch-stage constants and types: XLEN, the canonical NOP, the fetch FSM
// encoding and the buffered instruction entry.
package rv32_pkg;

  localparam int unsigned XLEN = 32;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] RV_NOP = 32'h0000_0013;

  typedef enum logic {
    FETCH = 1'b0,
    DROP  = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_addr(input logic [XLEN-1:0] byte_addr);
    return {2'b00, byte_addr[XLEN-1:2]};
  endfunction

endpackage

// File: rtl/if_fetch_ctrl_if.sv
// Fetch-stage bus bundle: instruction-memory request/response plus the IF->ID handshake.
// master = fetch controller, slave = memory + decode side.
interface if_fetch_ctrl_if
  import rv32_pkg::*;
;

  logic            imem_req_out;
  logic [XLEN-1:0] imem_addr_out;
  logic            imem_ready_in;
  logic [XLEN-1:0] imem_rdata_in;

  logic            id_ready_in;
  logic            inst_valid_out;
  logic [XLEN-1:0] inst_out;
  logic [XLEN-1:0] pc_out;
  logic [XLEN-1:0] pcPlus4_out;

  modport master (
    output imem_req_out,
    output imem_addr_out,
    input  imem_ready_in,
    input  imem_rdata_in,
    input  id_ready_in,
    output inst_valid_out,
    output inst_out,
    output pc_out,
    output pcPlus4_out
  );

  modport slave (
    input  imem_req_out,
    input  imem_addr_out,
    output imem_ready_in,
    output imem_rdata_in,
    output id_ready_in,
    input  inst_valid_out,
    input  inst_out,
    input  pc_out,
    input  pcPlus4_out
  );

endinterface

// File: rtl/if_fetch_fifo.sv
// Synchronous DEPTH-entry instruction buffer holding {inst, pc, pc+4}.
// Flush has priority over push and pop; DEPTH must be a power of two.
module if_fetch_fifo
  import rv32_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  fetch_entry_t           wdata,
  output fetch_entry_t           rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  fetch_entry_t  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // NOTE: storage is deliberately not reset; pointers and count alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= wdata;
  end

  assign rdata = r_mem[r_rd_ptr];
  assign full  = (r_count == CW'(DEPTH));
  assign empty = (r_count == '0);
  assign count = r_count;

endmodule

// File: rtl/if_fetch_ctrl.sv
// RV32I instruction-fetch sequencer: owns the PC, keeps one memory read outstanding,
// buffers returned words for ID and squashes stale work on EX redirects.
module if_fetch_ctrl
  import rv32_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned     DEPTH    = 2,
  parameter logic [XLEN-1:0] NOP_INST = RV_NOP
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              redirect_in,
  input  logic [XLEN-1:0]   redirect_pc_in,
  output logic              misalign_out,
  if_fetch_ctrl_if.master   bus
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  fetch_state_t    r_state;
  fetch_state_t    w_state_next;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_next;
  logic [XLEN-1:0] w_pc_plus4;
  logic [XLEN-1:0] r_drop_addr;
  logic [XLEN-1:0] w_addr;
  logic            r_misalign;
  logic            w_redirect;
  logic            w_req;
  logic            w_push;
  logic            w_pop;
  logic            w_full;
  logic            w_empty;
  logic [CNT_W-1:0] w_count;
  fetch_entry_t    w_wdata;
  fetch_entry_t    w_head;

  // NOTE: === folds an X/Z redirect to "no redirect" in simulation; synthesis sees a plain compare.
  assign w_redirect = (redirect_in === 1'b1);
  assign w_pc_plus4 = r_pc + XLEN'(4);

  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_req        = 1'b0;
    w_addr       = word_addr(r_pc);
    w_push       = 1'b0;
    w_pc_next    = r_pc;
    unique case (r_state)
      FETCH: begin
        w_req  = (w_count < CNT_W'(DEPTH));
        w_push = w_req && bus.imem_ready_in && !w_full && !w_redirect;
        if (w_redirect && w_req && !bus.imem_ready_in) w_state_next = DROP;
      end
      DROP: begin
        // Stale request still owed a response: keep it stable, discard the data.
        w_req  = 1'b1;
        w_addr = r_drop_addr;
        if (bus.imem_ready_in) w_state_next = FETCH;
      end
      default: w_state_next = FETCH;
    endcase
    if (w_redirect)  w_pc_next = {redirect_pc_in[XLEN-1:2], 2'b00};
    else if (w_push) w_pc_next = w_pc_plus4;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= FETCH;
      r_pc        <= RESET_PC;
      r_drop_addr <= '0;
      r_misalign  <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_pc       <= w_pc_next;
      r_misalign <= w_redirect && (redirect_pc_in[1:0] != 2'b00);
      if (r_state == FETCH && w_state_next == DROP) r_drop_addr <= w_addr;
    end
  end

  assign w_pop   = !w_empty && bus.id_ready_in && !w_redirect;
  assign w_wdata = '{inst: bus.imem_rdata_in, pc: r_pc, pc_plus4: w_pc_plus4};

  if_fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (w_push),
    .pop     (w_pop),
    .flush   (w_redirect),
    .wdata   (w_wdata),
    .rdata   (w_head),
    .full    (w_full),
    .empty   (w_empty),
    .count   (w_count)
  );

  assign bus.imem_req_out   = reset_n && w_req;
  assign bus.imem_addr_out  = w_addr;
  assign bus.inst_valid_out = !w_empty;
  assign bus.inst_out       = w_empty ? NOP_INST : w_head.inst;
  assign bus.pc_out         = w_empty ? '0 : w_head.pc;
  assign bus.pcPlus4_out    = w_empty ? '0 : w_head.pc_plus4;
  assign misalign_out       = r_misalign;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Scoreboard bench for if_fetch_ctrl: directed scenarios push expected {inst,pc,pc+4}
// entries; a negedge monitor pops and compares every accepted IF->ID transfer.
module tb_if_fetch_ctrl;
  import rv32_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pc4;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        redirect_in;
  logic [31:0] redirect_pc_in;
  logic        misalign_out;

  int checks = 0;
  int errors = 0;
  int mem_limit = 0;
  int mem_lat = 0;
  int r_grants = 0;
  int r_wait = 0;
  exp_t exp_q[$];

  if_fetch_ctrl_if fetch_if ();

  if_fetch_ctrl #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (2),
    .NOP_INST (NOP)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .redirect_in    (redirect_in),
    .redirect_pc_in (redirect_pc_in),
    .misalign_out   (misalign_out),
    .bus            (fetch_if)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h5A00_0000 | (a & 32'h00FF_FFFF);
  endfunction

  function automatic exp_t mk(input logic [31:0] pc);
    exp_t e;
    e.inst = mem_word({2'b00, pc[31:2]});
    e.pc   = pc;
    e.pc4  = pc + 32'd4;
    return e;
  endfunction

  // Memory model: answers after mem_lat wait cycles, at most mem_limit responses per reset.
  assign fetch_if.imem_ready_in = fetch_if.imem_req_out && (r_grants < mem_limit) && (r_wait >= mem_lat);
  assign fetch_if.imem_rdata_in = mem_word(fetch_if.imem_addr_out);

  always @(posedge clk) begin
    if (!reset_n) begin
      r_wait   <= 0;
      r_grants <= 0;
    end else if (fetch_if.imem_ready_in) begin
      r_wait   <= 0;
      r_grants <= r_grants + 1;
    end else if (fetch_if.imem_req_out) begin
      r_wait <= r_wait + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Monitor: a transfer happens when valid & ready at the edge, unless a redirect squashes it.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && fetch_if.inst_valid_out === 1'b1 &&
        fetch_if.id_ready_in === 1'b1 && redirect_in !== 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got pc %08h expected no transfer", fetch_if.pc_out);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_inst", fetch_if.inst_out, e.inst);
        check("sb_pc", fetch_if.pc_out, e.pc);
        check("sb_pc4", fetch_if.pcPlus4_out, e.pc4);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n              = 1'b0;
    redirect_in          = 1'b0;
    redirect_pc_in       = '0;
    fetch_if.id_ready_in = 1'b0;
    mem_limit            = 0;
    mem_lat              = 0;
    cyc(2);
  endtask

  task automatic release_rst(input int limit, input int lat, input logic idr);
    mem_limit            = limit;
    mem_lat              = lat;
    fetch_if.id_ready_in = idr;
    reset_n              = 1'b1;
  endtask

  task automatic drain(input string name, input int n);
    cyc(n);
    check(name, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset state, then zero-wait streaming at addr 0,1,2,...
    do_reset();
    neg();
    check("rst_req", 32'(fetch_if.imem_req_out), 32'd0);
    check("rst_valid", 32'(fetch_if.inst_valid_out), 32'd0);
    check("rst_inst", fetch_if.inst_out, NOP);
    check("rst_pc", fetch_if.pc_out, 32'd0);
    check("rst_pc4", fetch_if.pcPlus4_out, 32'd0);
    check("rst_misalign", 32'(misalign_out), 32'd0);
    cyc(1);
    for (int i = 0; i < 4; i++) exp_q.push_back(mk(32'(i * 4)));
    release_rst(4, 0, 1'b1);
    neg();
    check("t1_req_c1", 32'(fetch_if.imem_req_out), 32'd1);
    check("t1_addr_c1", fetch_if.imem_addr_out, 32'd0);
    check("t1_valid_c1", 32'(fetch_if.inst_valid_out), 32'd0);
    cyc(1); neg();
    check("t1_addr_c2", fetch_if.imem_addr_out, 32'd1);
    check("t1_valid_c2", 32'(fetch_if.inst_valid_out), 32'd1);
    cyc(1); neg();
    check("t1_addr_c3", fetch_if.imem_addr_out, 32'd2);
    drain("t1_drain", 8);

    // 2: ID stalls 5 cycles -> two buffered, no request while full; release in order.
    do_reset();
    for (int i = 0; i < 3; i++) exp_q.push_back(mk(32'(i * 4)));
    release_rst(3, 0, 1'b0);
    cyc(2); neg();
    check("t2_req_full_c3", 32'(fetch_if.imem_req_out), 32'd0);
    check("t2_valid_c3", 32'(fetch_if.inst_valid_out), 32'd1);
    check("t2_head_pc_c3", fetch_if.pc_out, 32'd0);
    cyc(1); neg();
    check("t2_req_full_c4", 32'(fetch_if.imem_req_out), 32'd0);
    cyc(1); neg();
    check("t2_req_full_c5", 32'(fetch_if.imem_req_out), 32'd0);
    cyc(1);
    fetch_if.id_ready_in = 1'b1;
    drain("t2_drain", 6);

    // 3: 3-cycle memory, redirect to 0x100 while waiting -> DROP, stale word discarded.
    do_reset();
    exp_q.push_back(mk(32'h0000_0100));
    release_rst(2, 3, 1'b1);
    cyc(1);
    redirect_in    = 1'b1;
    redirect_pc_in = 32'h0000_0100;
    neg();
    check("t3_addr_redir", fetch_if.imem_addr_out, 32'd0);
    cyc(1);
    redirect_in = 1'b0;
    neg();
    check("t3_drop_req", 32'(fetch_if.imem_req_out), 32'd1);
    check("t3_drop_addr", fetch_if.imem_addr_out, 32'd0);
    cyc(1); neg();
    check("t3_drop_addr_rdy", fetch_if.imem_addr_out, 32'd0);
    cyc(1); neg();
    check("t3_new_addr", fetch_if.imem_addr_out, 32'h0000_0040);
    check("t3_new_req", 32'(fetch_if.imem_req_out), 32'd1);
    check("t3_no_stale", 32'(fetch_if.inst_valid_out), 32'd0);
    drain("t3_drain", 8);

    // 4: redirect coincident with push and pop -> empty, NOP, fetch at target.
    do_reset();
    exp_q.push_back(mk(32'h0000_0200));
    exp_q.push_back(mk(32'h0000_0204));
    release_rst(4, 0, 1'b1);
    cyc(1);
    redirect_in    = 1'b1;
    redirect_pc_in = 32'h0000_0200;
    cyc(1);
    redirect_in = 1'b0;
    neg();
    check("t4_valid_flushed", 32'(fetch_if.inst_valid_out), 32'd0);
    check("t4_inst_nop", fetch_if.inst_out, NOP);
    check("t4_addr_target", fetch_if.imem_addr_out, 32'h0000_0080);
    drain("t4_drain", 6);

    // 5: misaligned redirect -> one-cycle misalign pulse, fetch at aligned 0x100.
    do_reset();
    exp_q.push_back(mk(32'h0000_0100));
    exp_q.push_back(mk(32'h0000_0104));
    release_rst(3, 0, 1'b1);
    redirect_in    = 1'b1;
    redirect_pc_in = 32'h0000_0102;
    neg();
    check("t5_misalign_c1", 32'(misalign_out), 32'd0);
    cyc(1);
    redirect_in = 1'b0;
    neg();
    check("t5_misalign_c2", 32'(misalign_out), 32'd1);
    check("t5_addr_aligned", fetch_if.imem_addr_out, 32'h0000_0040);
    cyc(1); neg();
    check("t5_misalign_c3", 32'(misalign_out), 32'd0);
    drain("t5_drain", 6);

    // 6: reset with a request pending and a full-then-partial buffer.
    do_reset();
    exp_q.push_back(mk(32'h0000_0000));
    release_rst(2, 0, 1'b0);
    cyc(3); neg();
    check("t6_full_req", 32'(fetch_if.imem_req_out), 32'd0);
    check("t6_full_valid", 32'(fetch_if.inst_valid_out), 32'd1);
    cyc(1);
    fetch_if.id_ready_in = 1'b1;
    cyc(1);
    fetch_if.id_ready_in = 1'b0;
    neg();
    check("t6_pending_req", 32'(fetch_if.imem_req_out), 32'd1);
    check("t6_head_pc", fetch_if.pc_out, 32'h0000_0004);
    cyc(1);
    reset_n = 1'b0;
    neg();
    check("t6_req_in_reset", 32'(fetch_if.imem_req_out), 32'd0);
    cyc(1);
    exp_q.push_back(mk(32'h0000_0000));
    release_rst(1, 0, 1'b1);
    neg();
    check("t6_valid_cleared", 32'(fetch_if.inst_valid_out), 32'd0);
    check("t6_inst_nop", fetch_if.inst_out, NOP);
    check("t6_req_after", 32'(fetch_if.imem_req_out), 32'd1);
    check("t6_addr_reset_pc", fetch_if.imem_addr_out, 32'd0);
    drain("t6_drain", 5);

    // 7: PC wrap from 0xFFFF_FFFC to 0 without any flag.
    do_reset();
    exp_q.push_back(mk(32'hFFFF_FFFC));
    exp_q.push_back(mk(32'h0000_0000));
    release_rst(3, 0, 1'b1);
    redirect_in    = 1'b1;
    redirect_pc_in = 32'hFFFF_FFFC;
    cyc(1);
    redirect_in = 1'b0;
    neg();
    check("t7_addr_top", fetch_if.imem_addr_out, 32'h3FFF_FFFF);
    check("t7_misalign", 32'(misalign_out), 32'd0);
    cyc(1); neg();
    check("t7_addr_wrap", fetch_if.imem_addr_out, 32'd0);
    drain("t7_drain", 6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
